mod6_count_ctrl: RTL and testbench

Sequential front end of the mod-6 counter display path. It holds a 0–5 count and advances it from two sources: a prescaled free-running tick, or a debounced pushbutton single-step, in either direction. Its 3-bit count drives the 3-bit binary-to-seven-segment decoder directly. A wrap pulse allows cascading further digits.

---
 rtl/mod6_count_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mod6_count_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod6_count_ctrl.sv
// ---------------------------------------------------------------------------
// mod6_count_ctrl
//
// Sequential front end of the mod-6 counter display path. Holds a 0..5 count
// and steps it up or down from two sources: a prescaled free-running tick
// while running, or a synchronized and debounced pushbutton press. The 3-bit
// count feeds the binary-to-seven-segment decoder directly, and a one-cycle
// carry pulse on every wrap lets further digits be cascaded.
//
// Optional feature macro: MOD6_DEBOUNCE_EN
//    defined   -> button level must be stable for P_DEBOUNCE_CYCLES cycles
//    undefined -> debounced level is the synchronizer output, no counter
//
// Parameters:
//    P_PRESCALE         clock cycles per automatic step (2 .. 2^32-1)
//    P_DEBOUNCE_CYCLES  stable cycles needed to accept a level (1 .. 2^24-1)
//
// Ports:
//    i_clk        system clock, rising edge
//    i_rst        asynchronous active-high reset
//    i_run        1 enables automatic counting from the prescaler
//    i_up_down    1 counts up, 0 counts down
//    i_step_btn   raw asynchronous pushbutton, active-high
//    i_clear      synchronous clear of the count
//    o_count      current count, always 0..5
//    o_carry      one-cycle pulse in the cycle that shows the wrapped value
//    o_tick       one-cycle prescaler tick
// ---------------------------------------------------------------------------
module mod6_count_ctrl #(
   parameter int unsigned P_PRESCALE        = 50_000_000,
   parameter int unsigned P_DEBOUNCE_CYCLES = 500_000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_run,
   input  logic       i_up_down,
   input  logic       i_step_btn,
   input  logic       i_clear,
   output logic [2:0] o_count,
   output logic       o_carry,
   output logic       o_tick
);

   localparam logic [31:0] PRESCALE_LAST = 32'(P_PRESCALE - 1);

   logic [31:0] prescaler_q, prescaler_d;
   logic        tick_q, tick_d;
   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        deb_level;
   logic        deb_prev_q, deb_prev_d;
   logic        step_pulse;
   logic        count_event;
   logic [2:0]  count_q, count_d;
   logic        carry_q, carry_d;

   // Prescaler: free-runs 0..P_PRESCALE-1 while running and raises the tick
   // for the cycle after it rolls over. Stopping parks it at 0 so a restart
   // always gives a full period before the first tick.
   always_comb begin
      prescaler_d = '0;
      tick_d      = 1'b0;
      if (i_run) begin
         if (prescaler_q == PRESCALE_LAST) begin
            prescaler_d = '0;
            tick_d      = 1'b1;
         end else begin
            prescaler_d = prescaler_q + 32'd1;
         end
      end
   end

   // Two-flop synchronizer for the asynchronous pushbutton.
   always_comb begin
      sync1_d = i_step_btn;
      sync2_d = sync1_q;
   end

`ifdef MOD6_DEBOUNCE_EN
   localparam logic [23:0] DEBOUNCE_LAST = 24'(P_DEBOUNCE_CYCLES - 1);

   logic [23:0] deb_cnt_q, deb_cnt_d;
   logic        deb_level_q, deb_level_d;

   // Debouncer: counts consecutive cycles in which the synchronized level
   // disagrees with the accepted level; any agreement restarts the count.
   // The level flips on the cycle the count would reach P_DEBOUNCE_CYCLES.
   always_comb begin
      deb_cnt_d   = '0;
      deb_level_d = deb_level_q;
      if (sync2_q != deb_level_q) begin
         if (deb_cnt_q == DEBOUNCE_LAST) begin
            deb_level_d = sync2_q;
            deb_cnt_d   = '0;
         end else begin
            deb_cnt_d = deb_cnt_q + 24'd1;
         end
      end
   end

   // Debouncer state registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         deb_cnt_q   <= '0;
         deb_level_q <= 1'b0;
      end else begin
         deb_cnt_q   <= deb_cnt_d;
         deb_level_q <= deb_level_d;
      end
   end

   assign deb_level = deb_level_q;
`else
   assign deb_level = sync2_q;
`endif

   // Rising-edge detector on the accepted button level; releases are ignored.
   always_comb begin
      deb_prev_d = deb_level;
      step_pulse = deb_level & ~deb_prev_q;
   end

   // Count update. Clear wins over everything, an out-of-range value is
   // recovered to 0 silently, and a tick coinciding with a button step is a
   // single event because they are OR-ed before use.
   always_comb begin
      count_d     = count_q;
      carry_d     = 1'b0;
      count_event = tick_q | step_pulse;
      if (i_clear) begin
         count_d = 3'd0;
      end else if (count_q > 3'd5) begin
         count_d = 3'd0;
      end else if (count_event) begin
         if (i_up_down) begin
            if (count_q == 3'd5) begin
               count_d = 3'd0;
               carry_d = 1'b1;
            end else begin
               count_d = count_q + 3'd1;
            end
         end else begin
            if (count_q == 3'd0) begin
               count_d = 3'd5;
               carry_d = 1'b1;
            end else begin
               count_d = count_q - 3'd1;
            end
         end
      end
   end

   // All remaining state registers share the asynchronous reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         prescaler_q <= '0;
         tick_q      <= 1'b0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         deb_prev_q  <= 1'b0;
         count_q     <= 3'd0;
         carry_q     <= 1'b0;
      end else begin
         prescaler_q <= prescaler_d;
         tick_q      <= tick_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         deb_prev_q  <= deb_prev_d;
         count_q     <= count_d;
         carry_q     <= carry_d;
      end
   end

   assign o_count = count_q;
   assign o_carry = carry_q;
   assign o_tick  = tick_q;

endmodule

// File: tb/tb_mod6_count_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mod6_count_ctrl
//
// Directed self-checking bench for mod6_count_ctrl with P_PRESCALE=4 and
// P_DEBOUNCE_CYCLES=3. Each driven cycle pushes the expected outputs onto a
// scoreboard queue; the entry is popped and compared once the DUT has
// clocked. Button timing expectations follow MOD6_DEBOUNCE_EN.
// ---------------------------------------------------------------------------
module tb_mod6_count_ctrl;

   localparam int P_PRESCALE        = 4;
   localparam int P_DEBOUNCE_CYCLES = 3;

`ifdef MOD6_DEBOUNCE_EN
   localparam int STEP_LAT      = 3 + P_DEBOUNCE_CYCLES;
   localparam bit GLITCH_STEPS  = 1'b0;
`else
   localparam int STEP_LAT      = 3;
   localparam bit GLITCH_STEPS  = 1'b1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic       upDown;
   logic       stepBtn;
   logic       clear;
   logic [2:0] count;
   logic       carry;
   logic       tick;

   typedef struct {
      string      tag;
      logic [2:0] count;
      logic       carry;
      logic       tick;
   } expect_t;

   expect_t scoreboard[$];
   int      total = 0;
   int      bad   = 0;
   int      expCount;
   logic    expTick;
   int      runEdges;

   mod6_count_ctrl #(
      .P_PRESCALE        (P_PRESCALE),
      .P_DEBOUNCE_CYCLES (P_DEBOUNCE_CYCLES)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_run      (run),
      .i_up_down  (upDown),
      .i_step_btn (stepBtn),
      .i_clear    (clear),
      .o_count    (count),
      .o_carry    (carry),
      .o_tick     (tick)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish, required finish by t=100000");
      $fatal(1, "[TB] watchdog expired");
   end

   // Queue one expected output set.
   task automatic pushExpect(input string tag, input int c, input logic cy, input logic tk);
      expect_t e;
      e.tag   = tag;
      e.count = 3'(c);
      e.carry = cy;
      e.tick  = tk;
      scoreboard.push_back(e);
   endtask

   // Pop the oldest expectation and compare it with the DUT outputs.
   task automatic checkOutput();
      expect_t e;
      if (scoreboard.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard_empty: got no entry, required one");
         return;
      end
      e = scoreboard.pop_front();
      total++;
      assert (count === e.count) else begin
         bad++;
         $error("[TB] FAIL %s count: got %0d required %0d", e.tag, count, e.count);
      end
      total++;
      assert (carry === e.carry) else begin
         bad++;
         $error("[TB] FAIL %s carry: got %0b required %0b", e.tag, carry, e.carry);
      end
      total++;
      assert (tick === e.tick) else begin
         bad++;
         $error("[TB] FAIL %s tick: got %0b required %0b", e.tag, tick, e.tick);
      end
   endtask

   // Drive one cycle of inputs, predict the outputs after the next rising
   // edge from the documented behaviour, then advance to the falling edge.
   // stepHere marks the edge at which a button step is due to land.
   task automatic applyStimulus(input logic clr, input logic btn, input bit stepHere,
                                input string tag);
      logic evt;
      logic carryNext;
      logic tickNext;
      int   nextCount;
      clear     = clr;
      stepBtn   = btn;
      evt       = expTick || stepHere;
      carryNext = 1'b0;
      nextCount = expCount;
      if (clr) begin
         nextCount = 0;
      end else if (evt) begin
         if (upDown) begin
            if (expCount == 5) begin
               nextCount = 0;
               carryNext = 1'b1;
            end else begin
               nextCount = expCount + 1;
            end
         end else begin
            if (expCount == 0) begin
               nextCount = 5;
               carryNext = 1'b1;
            end else begin
               nextCount = expCount - 1;
            end
         end
      end
      if (run) begin
         runEdges++;
         tickNext = ((runEdges % P_PRESCALE) == 0);
      end else begin
         runEdges = 0;
         tickNext = 1'b0;
      end
      expCount = nextCount;
      expTick  = tickNext;
      pushExpect(tag, nextCount, carryNext, tickNext);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Hold the button for 'hold' cycles out of 'cycles', expecting a single
   // step (or none) at STEP_LAT edges after the rise.
   task automatic press(input int hold, input int cycles, input bit expectStep,
                        input string tag);
      for (int c = 1; c <= cycles; c++) begin
         applyStimulus(logic'(c <= hold), logic'(c <= hold) == 1'b1 ? 1'b1 : 1'b0,
                       expectStep && (c == STEP_LAT), tag);
         checkOutput();
      end
   endtask

   initial begin
      rst      = 1'b1;
      run      = 1'b0;
      upDown   = 1'b1;
      stepBtn  = 1'b0;
      clear    = 1'b0;
      expCount = 0;
      expTick  = 1'b0;
      runEdges = 0;

      // Reset state.
      repeat (2) @(negedge clk);
      pushExpect("reset", 0, 1'b0, 1'b0);
      checkOutput();
      rst = 1'b0;

      // Automatic counting up through a full wrap.
      run    = 1'b1;
      upDown = 1'b1;
      for (int e = 1; e <= 27; e++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, "run_up");
         checkOutput();
      end
      run = 1'b0;
      for (int e = 1; e <= 2; e++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, "run_stop");
         checkOutput();
      end

      // Button steps counting down: 0 -> 5 with carry, then 4.
      upDown = 1'b0;
      press(10, 20, 1'b1, "btn_down1");
      press(10, 20, 1'b1, "btn_down2");

      // Short glitch, then a held press.
      press(2, 8, GLITCH_STEPS, "btn_glitch");
      press(5, 12, 1'b1, "btn_held");

      // Clear on its own.
      applyStimulus(1'b1, 1'b0, 1'b0, "clear_idle");
      checkOutput();

      // Count up to 3, clear against a tick, then a button step landing
      // together with a tick at count 2.
      run    = 1'b1;
      upDown = 1'b1;
      for (int e = 1; e <= 34; e++) begin
         applyStimulus(logic'(e == 17),
                       logic'((e >= 30 - STEP_LAT) && (e < 36 - STEP_LAT)),
                       (e == 29),
                       (e >= 17) ? ((e >= 26) ? "tick_and_step" : "clear_on_tick")
                                 : "count_to_3");
         checkOutput();
      end

      // Asynchronous reset between edges with count at 4.
      #2 rst = 1'b1;
      #1;
      pushExpect("async_reset", 0, 1'b0, 1'b0);
      checkOutput();
      @(negedge clk);
      rst      = 1'b0;
      run      = 1'b0;
      upDown   = 1'b1;
      expCount = 0;
      expTick  = 1'b0;
      runEdges = 0;
      press(4, 10, 1'b1, "post_reset_step");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
